// File: rtl/ysyx_24100005_pkg.sv
// Shared types for the multi-cycle sequencer: FSM state encoding, RV32I major
// opcodes and the EXEC-stage instruction classifier.
package ysyx_24100005_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_IWAIT,
        S_EXEC,
        S_MEM,
        S_DWAIT,
        S_WB,
        S_HALT
    } state_e;

    // What EXEC does with the latched instruction.
    typedef enum logic [1:0] {
        EX_WB,
        EX_MEM,
        EX_STOP,
        EX_FAULT
    } exec_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    // ebreak is the only SYSTEM encoding that stops cleanly; every other
    // SYSTEM encoding falls through to a fault.
    function automatic exec_e classify(input logic [31:0] inst);
        exec_e kind;
        if (inst == INST_EBREAK) begin
            kind = EX_STOP;
        end else begin
            unique case (inst[6:0])
                OP_LOAD, OP_STORE:                     kind = EX_MEM;
                OP_OP, OP_OP_IMM, OP_LUI, OP_AUIPC,
                OP_JAL, OP_JALR, OP_BRANCH:            kind = EX_WB;
                default:                               kind = EX_FAULT;
            endcase
        end
        return kind;
    endfunction

    function automatic logic is_store(input logic [6:0] opcode);
        return opcode == OP_STORE;
    endfunction

    // Stores and branches retire without a register-file write.
    function automatic logic writes_rf(input logic [6:0] opcode);
        return !(opcode == OP_STORE || opcode == OP_BRANCH);
    endfunction

endpackage

// File: rtl/ysyx_24100005_wdog.sv
// Wait-state watchdog: counts cycles spent in one wait state and flags the
// cycle in which the count reaches TIMEOUT_CYC.
module ysyx_24100005_wdog #(
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // cnt_q holds the number of earlier cycles in this state, so the current
    // cycle is the TIMEOUT_CYC-th one when cnt_q equals CNT_LAST.
    assign expire = enable && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != CNT_LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ysyx_24100005_seq_ctrl.sv
// Multi-cycle control sequencer: FETCH/IWAIT/EXEC/MEM/DWAIT/WB/HALT with
// valid/ready memory handshakes, a wait-state watchdog and registered outputs.
module ysyx_24100005_seq_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] inst,
    output logic        dmem_req_valid,
    output logic        dmem_req_wen,
    input  logic        dmem_req_ready,
    input  logic        dmem_rsp_valid,
    output logic        pc_wen,
    output logic        rf_wen,
    output logic        halt,
    output logic        err,
    output logic [31:0] retire_cnt
);

    import ysyx_24100005_pkg::*;

    state_e      state_q, state_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] retire_cnt_q, retire_cnt_d;
    logic        err_q, err_d;
    logic        halt_q, halt_d;
    logic        imem_req_valid_q, imem_req_valid_d;
    logic        dmem_req_valid_q, dmem_req_valid_d;
    logic        dmem_req_wen_q, dmem_req_wen_d;
    logic        pc_wen_q, pc_wen_d;
    logic        rf_wen_q, rf_wen_d;

    logic        wd_clear;
    logic        wd_enable;
    logic        wd_expire;

    assign wd_enable = (state_q == S_FETCH) || (state_q == S_IWAIT) ||
                       (state_q == S_MEM)   || (state_q == S_DWAIT);
    assign wd_clear  = (state_d != state_q);

    ysyx_24100005_wdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expire (wd_expire)
    );

    // A handshake completing in the expiry cycle takes priority over the
    // timeout, since the awaited event did arrive within the window.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        inst_d       = inst_q;
        retire_cnt_d = retire_cnt_q;
        err_d        = err_q;

        unique case (state_q)
            S_FETCH: begin
                if (imem_req_ready) begin
                    state_d = S_IWAIT;
                end else if (wd_expire) begin
                    state_d = S_HALT;
                    err_d   = 1'b1;
                end
            end
            S_IWAIT: begin
                if (imem_rsp_valid) begin
                    inst_d  = imem_rsp_data;
                    state_d = S_EXEC;
                end else if (wd_expire) begin
                    state_d = S_HALT;
                    err_d   = 1'b1;
                end
            end
            S_EXEC: begin
                unique case (classify(inst_q))
                    EX_MEM:   state_d = S_MEM;
                    EX_WB:    state_d = S_WB;
                    EX_STOP:  state_d = S_HALT;
                    EX_FAULT: begin
                        state_d = S_HALT;
                        err_d   = 1'b1;
                    end
                    default:  state_d = S_HALT;
                endcase
            end
            S_MEM: begin
                if (dmem_req_ready) begin
                    state_d = S_DWAIT;
                end else if (wd_expire) begin
                    state_d = S_HALT;
                    err_d   = 1'b1;
                end
            end
            S_DWAIT: begin
                if (dmem_rsp_valid) begin
                    state_d = S_WB;
                end else if (wd_expire) begin
                    state_d = S_HALT;
                    err_d   = 1'b1;
                end
            end
            S_WB: begin
                retire_cnt_d = retire_cnt_q + 32'd1;
                state_d      = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

    // Outputs are decoded from the next state and registered, so each one
    // lines up with the state it describes and no input reaches a port
    // combinationally.
    always_comb begin
        imem_req_valid_d = (state_d == S_FETCH);
        dmem_req_valid_d = (state_d == S_MEM);
        dmem_req_wen_d   = (state_d == S_MEM) && is_store(inst_d[6:0]);
        pc_wen_d         = (state_d == S_WB);
        rf_wen_d         = (state_d == S_WB) && writes_rf(inst_d[6:0]);
        halt_d           = (state_d == S_HALT);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q          <= S_FETCH;
            inst_q           <= '0;
            retire_cnt_q     <= '0;
            err_q            <= 1'b0;
            halt_q           <= 1'b0;
            imem_req_valid_q <= 1'b1;
            dmem_req_valid_q <= 1'b0;
            dmem_req_wen_q   <= 1'b0;
            pc_wen_q         <= 1'b0;
            rf_wen_q         <= 1'b0;
        end else begin
            state_q          <= state_d;
            inst_q           <= inst_d;
            retire_cnt_q     <= retire_cnt_d;
            err_q            <= err_d;
            halt_q           <= halt_d;
            imem_req_valid_q <= imem_req_valid_d;
            dmem_req_valid_q <= dmem_req_valid_d;
            dmem_req_wen_q   <= dmem_req_wen_d;
            pc_wen_q         <= pc_wen_d;
            rf_wen_q         <= rf_wen_d;
        end
    end

    assign imem_req_valid = imem_req_valid_q;
    assign dmem_req_valid = dmem_req_valid_q;
    assign dmem_req_wen   = dmem_req_wen_q;
    assign pc_wen         = pc_wen_q;
    assign rf_wen         = rf_wen_q;
    assign halt           = halt_q;
    assign err            = err_q;
    assign inst           = inst_q;
    assign retire_cnt     = retire_cnt_q;

endmodule

// File: doc/ysyx_24100005_seq_ctrl.md
YSYX_24100005_SEQ_CTRL -- requirements
Module: ysyx_24100005_seq_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 256, max consecutive cycles spent in one wait state before a timeout halt.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  in  1  sole clock, all state updates on rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 imem_req_valid  out  1  instruction fetch request.
REQ-006 imem_req_ready  in  1  fetch request accepted this cycle.
REQ-007 imem_rsp_valid  in  1  fetch data valid.
REQ-008 imem_rsp_data  in  32  fetched instruction.
REQ-009 inst  out  32  latched current instruction, drives datapath decode.
REQ-010 dmem_req_valid  out  1  data memory request.
REQ-011 dmem_req_wen  out  1  request is a store (1) or load (0); valid only with dmem_req_valid.
REQ-012 dmem_req_ready  in  1  data request accepted this cycle.
REQ-013 dmem_rsp_valid  in  1  data access complete.
REQ-014 pc_wen  out  1  one-cycle pulse, PC register loads next PC.
REQ-015 rf_wen  out  1  one-cycle pulse, register file write enable.
REQ-016 halt  out  1  core stopped; sticky until reset.
REQ-017 err  out  1  halt caused by timeout or illegal opcode; sticky until reset.
REQ-018 retire_cnt  out  32  retired-instruction count.

Function
REQ-019 States: FETCH, IWAIT, EXEC, MEM, DWAIT, WB, HALT; exactly one active.
REQ-020 FETCH: imem_req_valid=1; imem_req_ready -> IWAIT, else stay.
REQ-021 IWAIT: imem_rsp_valid -> latch imem_rsp_data into inst, go to EXEC; else stay.
REQ-022 EXEC (always 1 cycle), on inst[6:0]: 0000011 or 0100011 -> MEM; inst==32'h00100073 -> HALT, err=0; opcodes 0110011, 0010011, 0110111, 0010111, 1101111, 1100111, 1100011 -> WB; any other value, including other 1110011 encodings -> HALT, err=1.
REQ-023 MEM: dmem_req_valid=1, dmem_req_wen=1 iff store; dmem_req_ready -> DWAIT.
REQ-024 DWAIT: dmem_rsp_valid -> WB.
REQ-025 WB (1 cycle): pc_wen=1; rf_wen=1 unless opcode is 0100011 or 1100011; retire_cnt+1 (wraps 32'hFFFFFFFF -> 0); -> FETCH.
REQ-026 Minimum latency with zero-wait memory: non-memory instruction 4 cycles, load/store 6 cycles, FETCH entry to next FETCH entry.
REQ-027 Request valid held high until accepted; valid is not dropped while waiting.
REQ-028 Response strobes in any state other than IWAIT/DWAIT are ignored, and no state changes on them.
REQ-029 Wait counter resets on every state change and increments each cycle in FETCH, IWAIT, MEM, DWAIT; reaching TIMEOUT_CYC -> HALT with err=1.
REQ-030 HALT: all request/pulse outputs 0, inst and retire_cnt frozen; exit only via rst.
REQ-031 pc_wen and rf_wen are never asserted outside WB.

Reset
REQ-032 rst forces state FETCH, inst=0, retire_cnt=0, wait counter=0, halt=0, err=0; all request/pulse outputs 0 in the reset cycle.
REQ-033 rst mid-transaction abandons it; a late response after reset is ignored per REQ-028; the first post-reset cycle asserts imem_req_valid.

Structure
REQ-034 Shared package ysyx_24100005_pkg holds the state enum and the RV32I opcode constants.
REQ-035 Timeout counter is sub-module ysyx_24100005_wdog (clear, enable, expire output, TIMEOUT_CYC parameter).
REQ-036 Outputs are registered state decodes; no combinational path from inputs to imem_req_valid or dmem_req_valid.

Verification
REQ-037 addi (32'h00100093), zero-wait memories -> pc_wen and rf_wen each pulse once, 4 cycles after FETCH entry; retire_cnt=1.
REQ-038 sw (32'h00112023), imem_req_ready low 3 cycles, dmem_rsp_valid 2 cycles after acceptance -> dmem_req_wen=1, rf_wen=0, pc_wen once.
REQ-039 ebreak 32'h00100073 -> halt=1, err=0 the cycle after EXEC; later response strobes cause no outputs.
REQ-040 imem_rsp_valid never asserted, TIMEOUT_CYC=8 -> halt=1, err=1 after 8 IWAIT cycles.
REQ-041 Fetch data 32'h0000007F -> halt=1, err=1, retire_cnt unchanged.
REQ-042 rst asserted in DWAIT, then dmem_rsp_valid -> state FETCH, retire_cnt=0, no pc_wen/rf_wen pulse.
